// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with ALU flags.
// Each stage resolves NBLK/PIPE slices and forwards the unprocessed operand bits.
module csel_adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned NPS  = NBLK / PIPE;
  localparam int unsigned SW   = NPS * BLOCK;

  logic w_en;

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    localparam int unsigned RW = WIDTH - k * SW;
    localparam int unsigned OW = (k + 1) * SW;

    logic [RW-1:0] w_ain;
    logic [RW-1:0] w_bin;
    logic          w_cin;
    logic          w_vin;
    logic [SW-1:0] w_slice;
    logic          w_cout;
    logic [OW-1:0] w_sout;
    logic [OW-1:0] r_s;
    logic          r_c;
    logic          r_v;

    if (k == 0) begin : g_first
      assign w_ain  = i_a;
      assign w_bin  = i_sub ? ~i_b : i_b;
      assign w_cin  = i_sub | i_ci;
      assign w_vin  = i_in_valid;
      assign w_sout = w_slice;
    end else begin : g_next
      assign w_ain  = g_stage[k-1].g_fwd.r_a;
      assign w_bin  = g_stage[k-1].g_fwd.r_b;
      assign w_cin  = g_stage[k-1].r_c;
      assign w_vin  = g_stage[k-1].r_v;
      assign w_sout = {w_slice, g_stage[k-1].r_s};
    end

    always_comb begin
      logic [BLOCK:0] w_sum0;
      logic [BLOCK:0] w_sum1;
      logic           w_c;
      w_c     = w_cin;
      w_slice = '0;
      w_sum0  = '0;
      w_sum1  = '0;
      for (int unsigned j = 0; j < NPS; j++) begin
        w_sum0 = {1'b0, w_ain[j*BLOCK +: BLOCK]} + {1'b0, w_bin[j*BLOCK +: BLOCK]};
        w_sum1 = {1'b0, w_ain[j*BLOCK +: BLOCK]} + {1'b0, w_bin[j*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
        w_slice[j*BLOCK +: BLOCK] = w_c ? w_sum1[BLOCK-1:0] : w_sum0[BLOCK-1:0];
        w_c = w_sum0[BLOCK] | (w_c & w_sum1[BLOCK]);
      end
      w_cout = w_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_en) begin
        r_v <= w_vin;
        r_s <= w_sout;
        r_c <= w_cout;
      end
    end

    if (k < PIPE - 1) begin : g_fwd
      logic [RW-SW-1:0] r_a;
      logic [RW-SW-1:0] r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_ain[RW-1:SW];
          r_b <= w_bin[RW-1:SW];
        end
      end
    end else begin : g_out
      logic w_cmsb;
      logic r_ovf;
      logic r_zero;
      logic r_neg;
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign w_cmsb = w_sout[WIDTH-1] ^ w_ain[RW-1] ^ w_bin[RW-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_en) begin
          r_ovf  <= w_cmsb ^ w_cout;
          r_zero <= (w_sout == '0);
          r_neg  <= w_sout[WIDTH-1];
        end
      end
    end
  end

  assign o_out_valid = g_stage[PIPE-1].r_v;
  assign w_en        = ~o_out_valid | i_out_ready;
  assign o_in_ready  = w_en;
  assign o_s         = g_stage[PIPE-1].r_s;
  assign o_co        = g_stage[PIPE-1].r_c;
  assign o_ovf       = g_stage[PIPE-1].g_out.r_ovf;
  assign o_zero      = g_stage[PIPE-1].g_out.r_zero;
  assign o_neg       = g_stage[PIPE-1].g_out.r_neg;

endmodule
